// File: rtl/rca_pl_arbiter_if.sv
// Bus between the two requesters, the arbiter and the shared pipelined adder.
// Signal names follow the block's port list; the arbiter uses the slave view.
interface rca_pl_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0, cin0, req1, cin1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout, done0, done1;

  modport slave (
    input  req0, a0, b0, cin0, req1, a1, b1, cin1, add_sum, add_cout,
    output gnt0, gnt1, add_a, add_b, add_cin, res_sum, res_cout, done0, done1
  );

  modport master (
    output req0, a0, b0, cin0, req1, a1, b1, cin1, add_sum, add_cout,
    input  gnt0, gnt1, add_a, add_b, add_cin, res_sum, res_cout, done0, done1
  );
endinterface

// File: rtl/rca_pl_arbiter.sv
// Round-robin share of one LAT-stage pipelined adder between two requesters;
// a tag pipe follows each issue so its result returns to the right owner.
module rca_pl_arbiter #(
  parameter int WIDTH = 4,
  parameter int LAT   = 2
) (
  input  logic           clk,
  input  logic           rst,
  rca_pl_arbiter_if.slave bus
);

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  // Stage 0 is written on the issue edge, so the entry leaves stage LAT on
  // the edge where the adder output has been stable for a full cycle.
  tag_t [LAT:0]     tag_q, tag_d;

  logic elig0, elig1, issue, win1;
  tag_t tag_out;

  assign elig0   = bus.req0 & ~gnt0_q;
  assign elig1   = bus.req1 & ~gnt1_q;
  assign issue   = elig0 | elig1;
  assign win1    = elig1 & (~elig0 | ptr_q);
  assign tag_out = tag_q[LAT];

  always_comb begin
    gnt0_d     = issue & ~win1;
    gnt1_d     = issue &  win1;
    ptr_d      = ptr_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_cin_d  = add_cin_q;
    if (issue) begin
      ptr_d     = ~win1;
      add_a_d   = win1 ? bus.a1   : bus.a0;
      add_b_d   = win1 ? bus.b1   : bus.b0;
      add_cin_d = win1 ? bus.cin1 : bus.cin0;
    end
    tag_d[0].vld = issue;
    tag_d[0].id  = win1;
    for (int i = 1; i <= LAT; i++) tag_d[i] = tag_q[i-1];
    done0_d    = tag_out.vld & ~tag_out.id;
    done1_d    = tag_out.vld &  tag_out.id;
    res_sum_d  = tag_out.vld ? bus.add_sum  : res_sum_q;
    res_cout_d = tag_out.vld ? bus.add_cout : res_cout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      ptr_q      <= 1'b0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_cin_q  <= 1'b0;
      tag_q      <= '0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
    end else begin
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      ptr_q      <= ptr_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      add_cin_q  <= add_cin_d;
      tag_q      <= tag_d;
      res_sum_q  <= res_sum_d;
      res_cout_q <= res_cout_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.add_a    = add_a_q;
  assign bus.add_b    = add_b_q;
  assign bus.add_cin  = add_cin_q;
  assign bus.res_sum  = res_sum_q;
  assign bus.res_cout = res_cout_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;

  a_one_done: assert property (@(posedge clk) disable iff (rst) !(done0_q && done1_q));
  a_one_gnt:  assert property (@(posedge clk) disable iff (rst) !(gnt0_q && gnt1_q));

endmodule

// File: tb/tb_rca_pl_arbiter.sv
// Directed bench: per-cycle vector table for arbitration, ordering and results,
// plus hand sequences for reset and reset-in-flight. Adder modelled as 2 registers.
module tb_rca_pl_arbiter;
  localparam int W  = 4;
  localparam int NV = 32;

  typedef struct {
    logic         r0, c0, r1, c1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         g0, g1, d0, d1;
    logic [W-1:0] rs;
    logic         rc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  vec_t tv [NV];

  rca_pl_arbiter_if #(.WIDTH(W)) bus ();
  rca_pl_arbiter #(.WIDTH(W), .LAT(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // external adder: operands registered twice, sum valid two edges later
  logic [W:0] s1_q, s2_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{W{1'b0}}, bus.add_cin};
      s2_q <= s1_q;
    end
  end
  assign bus.add_sum  = s2_q[W-1:0];
  assign bus.add_cout = s2_q[W];

  function automatic vec_t mk(int r0, int a0, int b0, int c0, int r1, int a1, int b1, int c1,
                              int g0, int g1, int d0, int d1, int rs, int rc);
    vec_t v;
    v.r0 = 1'(r0); v.a0 = W'(a0); v.b0 = W'(b0); v.c0 = 1'(c0);
    v.r1 = 1'(r1); v.a1 = W'(a1); v.b1 = W'(b1); v.c1 = 1'(c1);
    v.g0 = 1'(g0); v.g1 = 1'(g1); v.d0 = 1'(d0); v.d1 = 1'(d1);
    v.rs = W'(rs); v.rc = 1'(rc);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.req0 = v.r0; bus.a0 = v.a0; bus.b0 = v.b0; bus.cin0 = v.c0;
    bus.req1 = v.r1; bus.a1 = v.a1; bus.b1 = v.b1; bus.cin1 = v.c1;
  endtask

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s t=%0d got=%0h want=%0h", nm, t, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {23'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.res_cout, bus.res_sum};
  endfunction

  function automatic logic [31:0] expo(input vec_t v);
    return {23'd0, v.g0, v.g1, v.d0, v.d1, v.rc, v.rs};
  endfunction

  function automatic logic [31:0] adds();
    return {23'd0, bus.add_cin, bus.add_b, bus.add_a};
  endfunction

  initial begin
    vec_t z, v;
    // requests rise together from pointer 0: gnt0, gnt1, then done0, done1
    tv[0]  = mk(1,11,10,1, 1,8,8,0,   0,0,0,0, 0,0);
    tv[1]  = mk(0,0,0,0,   1,8,8,0,   1,0,0,0, 0,0);
    tv[2]  = mk(0,0,0,0,   0,0,0,0,   0,1,0,0, 0,0);
    tv[3]  = mk(0,0,0,0,   0,0,0,0,   0,0,0,0, 0,0);
    tv[4]  = mk(0,0,0,0,   0,0,0,0,   0,0,1,0, 6,1);
    tv[5]  = mk(0,0,0,0,   0,0,0,0,   0,0,0,1, 0,1);
    // both held 8 cycles: 3+4+0=7/c0 and 15+15+1=F/c1, alternating
    tv[6]  = mk(1,3,4,0,   1,15,15,1, 0,0,0,0, 0,1);
    tv[7]  = mk(1,3,4,0,   1,15,15,1, 1,0,0,0, 0,1);
    tv[8]  = mk(1,3,4,0,   1,15,15,1, 0,1,0,0, 0,1);
    tv[9]  = mk(1,3,4,0,   1,15,15,1, 1,0,0,0, 0,1);
    tv[10] = mk(1,3,4,0,   1,15,15,1, 0,1,1,0, 7,0);
    tv[11] = mk(1,3,4,0,   1,15,15,1, 1,0,0,1, 15,1);
    tv[12] = mk(1,3,4,0,   1,15,15,1, 0,1,1,0, 7,0);
    tv[13] = mk(1,3,4,0,   1,15,15,1, 1,0,0,1, 15,1);
    tv[14] = mk(0,0,0,0,   0,0,0,0,   0,1,1,0, 7,0);
    tv[15] = mk(0,0,0,0,   0,0,0,0,   0,0,0,1, 15,1);
    tv[16] = mk(0,0,0,0,   0,0,0,0,   0,0,1,0, 7,0);
    tv[17] = mk(0,0,0,0,   0,0,0,0,   0,0,0,1, 15,1);
    tv[18] = mk(0,0,0,0,   0,0,0,0,   0,0,0,0, 15,1);
    // req0 only: 1001+1011+0 -> 0100/c1 three cycles after gnt0
    tv[19] = mk(1,9,11,0,  0,0,0,0,   0,0,0,0, 15,1);
    tv[20] = mk(0,0,0,0,   0,0,0,0,   1,0,0,0, 15,1);
    tv[21] = mk(0,0,0,0,   0,0,0,0,   0,0,0,0, 15,1);
    tv[22] = mk(0,0,0,0,   0,0,0,0,   0,0,0,0, 15,1);
    tv[23] = mk(0,0,0,0,   0,0,0,0,   0,0,1,0, 4,1);
    // req1 only 1100+1001+1, then both: requester 0 is next
    tv[24] = mk(0,0,0,0,   1,12,9,1,  0,0,0,0, 4,1);
    tv[25] = mk(1,1,1,0,   1,2,2,0,   0,1,0,0, 4,1);
    tv[26] = mk(0,0,0,0,   1,2,2,0,   1,0,0,0, 4,1);
    tv[27] = mk(0,0,0,0,   0,0,0,0,   0,1,0,0, 4,1);
    tv[28] = mk(0,0,0,0,   0,0,0,0,   0,0,0,1, 6,1);
    tv[29] = mk(0,0,0,0,   0,0,0,0,   0,0,1,0, 2,0);
    tv[30] = mk(0,0,0,0,   0,0,0,0,   0,0,0,1, 4,0);
    tv[31] = mk(0,0,0,0,   0,0,0,0,   0,0,0,0, 4,0);

    z = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0);

    // reset holds everything at 0 even with a request pending
    v = z; v.r0 = 1'b1; v.a0 = 4'd5; v.b0 = 4'd6;
    drive(v);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_outs", i, outs(), 32'd0);
      chk("reset_add", i, adds(), 32'd0);
    end
    drive(z);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < NV; t++) begin
      @(negedge clk);
      drive(tv[t]);
      chk("vec_outs", t, outs(), expo(tv[t]));
      if (t > 0 && tv[t].g0)
        chk("vec_add0", t, adds(), {23'd0, tv[t-1].c0, tv[t-1].b0, tv[t-1].a0});
      if (t > 0 && tv[t].g1)
        chk("vec_add1", t, adds(), {23'd0, tv[t-1].c1, tv[t-1].b1, tv[t-1].a1});
    end

    // reset one cycle after gnt0: the in-flight operation never completes
    @(negedge clk);
    v = z; v.r0 = 1'b1; v.a0 = 4'd5; v.b0 = 4'd5;
    drive(v);
    @(negedge clk);
    chk("rst_flight_gnt", 0, outs(), {23'd0, 9'b1_0_0_0_0_0100});
    drive(z);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_flight_outs", 1, outs(), 32'd0);
    chk("rst_flight_add", 1, adds(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_flight_quiet", i, outs(), 32'd0);
      chk("rst_flight_addq", i, adds(), 32'd0);
    end

    // recovery: req1 alone 3+3+1 -> 0111/c0
    v = z; v.r1 = 1'b1; v.a1 = 4'd3; v.b1 = 4'd3; v.c1 = 1'b1;
    drive(v);
    @(negedge clk);
    drive(z);
    chk("recov_gnt1", 0, outs(), {23'd0, 9'b0_1_0_0_0_0000});
    chk("recov_add", 0, adds(), {23'd0, 1'b1, 4'd3, 4'd3});
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("recov_done1", 0, outs(), {23'd0, 9'b0_0_0_1_0_0111});
    @(negedge clk);
    chk("recov_hold", 0, outs(), {23'd0, 9'b0_0_0_0_0_0111});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout t=0 got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
